mem_arbiter: RTL and testbench

- Sits directly downstream of the icache and dcache and upstream of the single-ported RAM.
- Arbitrates word requests from both caches onto the RAM port, with dcache priority.
- Registers each request before driving RAM, returns the load word, and releases the winning cache's wait for exactly one cycle.
- Keeps a dcache two-word block transfer (word 0, then word 1) from being split by an icache access, and guards against a hung RAM with a timeout.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the icache, dcache and RAM side signals of the memory arbiter.
//   slave  : the arbiter's view (cache requests and RAM data in; waits, loads and RAM controls out)
//   master : the environment's view (caches plus RAM), directions mirrored
//   icache : iREN, iaddr -> ; <- iwait, iload
//   dcache : dREN, dWEN, daddr, dstore -> ; <- dwait, dload
//   RAM    : <- ramREN, ramWEN, ramaddr, ramstore ; ramload, ram_ready ->
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates icache and dcache word accesses onto a single-ported RAM.
//   dcache has priority; a dcache word-0 access locks out the icache until the
//   matching word-1 access completes so a two-word block is never split.
//   Each access is registered onto the RAM port, completes on ram_ready or on
//   a timeout, and releases the winning cache's wait low for one cycle.
//
// Ports:
//   CLK, nRST  clock, asynchronous active-low reset
//   bus        mem_arbiter_if.slave (cache request/response and RAM port)
//   arb_err    sticky, set whenever an access times out
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles spent in an access state (1..255)
//   ERR_WORD        load value returned on a timed-out access
//
// Optional feature (macro ARB_FAIR_EN):
//   After three consecutive dcache grants made while the icache was
//   requesting, the next IDLE grant goes to the icache (when not block-locked).
//   Undefined: strict dcache priority.
//
// state  | meaning
// IDLE   | no access in flight, choose a requester
// D_ACC  | dcache access driven on RAM, waiting for ram_ready / timeout
// I_ACC  | icache access driven on RAM, waiting for ram_ready / timeout
// D_DONE | dwait low for this single cycle
// I_DONE | iwait low for this single cycle
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_WORD       = 32'hBAD1BAD1
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus,
  output logic         arb_err
);

  typedef enum logic [2:0] {IDLE, D_ACC, I_ACC, D_DONE, I_DONE} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        blk_lock;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;
  logic [31:0] iload_r, dload_r;

  logic grant_d, grant_i;
  logic acc_ready, acc_timeout, acc_end;
  logic in_acc;
  logic fair_pick_i;

  assign in_acc  = (state == D_ACC) || (state == I_ACC);
  assign acc_end = acc_ready || acc_timeout;

`ifdef ARB_FAIR_EN
  logic [1:0] fair_cnt;

  assign fair_pick_i = (fair_cnt == 2'd3) && !blk_lock && bus.iREN;

  // Counts dcache grants won while the icache was also asking; saturates at 3.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fair_cnt <= 2'd0;
    end else if (grant_i) begin
      fair_cnt <= 2'd0;
    end else if (grant_d) begin
      if (!bus.iREN)
        fair_cnt <= 2'd0;
      else if (fair_cnt != 2'd3)
        fair_cnt <= fair_cnt + 2'd1;
    end
  end
`else
  assign fair_pick_i = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    acc_ready   = 1'b0;
    acc_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (fair_pick_i) begin
          grant_i   = 1'b1;
          state_nxt = I_ACC;
        end else if (bus.dREN || bus.dWEN) begin
          grant_d   = 1'b1;
          state_nxt = D_ACC;
        end else if (bus.iREN && !blk_lock) begin
          grant_i   = 1'b1;
          state_nxt = I_ACC;
        end
      end
      D_ACC, I_ACC: begin
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (bus.ram_ready)
          acc_ready = 1'b1;
        else if (cnt + 8'd1 == TO_LIM)
          acc_timeout = 1'b1;
        if (acc_ready || acc_timeout)
          state_nxt = (state == D_ACC) ? D_DONE : I_DONE;
      end
      D_DONE, I_DONE: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt       <= 8'd0;
      blk_lock  <= 1'b0;
      arb_err   <= 1'b0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= 32'd0;
      ram_store <= 32'd0;
      iload_r   <= 32'd0;
      dload_r   <= 32'd0;
    end else begin
      cnt <= (in_acc && !acc_end) ? cnt + 8'd1 : 8'd0;

      if (grant_d) begin
        ram_ren   <= bus.dREN;
        ram_wen   <= bus.dWEN;
        ram_addr  <= bus.daddr;
        ram_store <= bus.dstore;
      end else if (grant_i) begin
        ram_ren  <= 1'b1;
        ram_wen  <= 1'b0;
        ram_addr <= bus.iaddr;
      end

      if (acc_end) begin
        ram_ren <= 1'b0;
        ram_wen <= 1'b0;
        if (state == D_ACC) begin
          // Word 0 of a block locks out the icache until word 1 is done.
          blk_lock <= ~ram_addr[2];
          if (acc_timeout)
            dload_r <= ERR_WORD;
          else if (ram_ren)
            dload_r <= bus.ramload;
        end else begin
          if (acc_timeout)
            iload_r <= ERR_WORD;
          else
            iload_r <= bus.ramload;
        end
      end

      if (acc_timeout)
        arb_err <= 1'b1;
    end
  end

  assign bus.iwait    = (state != I_DONE);
  assign bus.dwait    = (state != D_DONE);
  assign bus.iload    = iload_r;
  assign bus.dload    = dload_r;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives both caches and a RAM responder with randomized traffic. A
//   transaction-level model predicts the RAM access order and every cache
//   response; monitors pop and compare whenever the DUT presents an access or
//   a wait pulse.
module tb_mem_arbiter;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRW = 32'hBAD1BAD1;

  logic clk, nrst, arb_err;
  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_WORD(ERRW)) dut (
    .CLK(clk), .nRST(nrst), .bus(bus), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] data; int lat; } ram_exp_t;
  typedef struct { logic is_rd; logic [31:0] data; logic err; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; int lat; int gap; } dreq_t;

  ram_exp_t ram_q[$];
  rsp_t     dq[$], iq[$];
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  logic       m_lock, m_err;
  logic [1:0] m_fair;
  int round_c0, last_d_cyc, last_i_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction
  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : seed_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  function automatic dreq_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                               input int lat, input int gap);
    dreq_t r;
    r.we = we; r.addr = a; r.data = d; r.lat = lat; r.gap = gap;
    return r;
  endfunction

  // Transaction-level arbitration: dcache first, icache blocked while a block
  // is half done, optional fairness override. Produces RAM order and responses.
  task automatic predict(input dreq_t dl[$], input bit i_en, input logic [31:0] ia, input int ilat);
    int di;
    bit ip, pick_i;
    rsp_t r;
    logic [31:0] a;
    di = 0;
    ip = i_en;
    while (di < dl.size() || ip) begin
      pick_i = 1'b0;
`ifdef ARB_FAIR_EN
      if (ip && m_fair == 2'd3 && !m_lock) pick_i = 1'b1;
`endif
      if (!pick_i && di < dl.size()) begin
        a = dl[di].addr;
        ram_q.push_back('{addr: a, we: dl[di].we, data: dl[di].data, lat: dl[di].lat});
        if (dl[di].lat < 0) m_err = 1'b1;
        r.is_rd = !dl[di].we;
        r.err   = m_err;
        if (dl[di].we) begin
          r.data = 32'd0;
          if (dl[di].lat >= 0) ref_mem[a] = dl[di].data;
        end else begin
          r.data = (dl[di].lat < 0) ? ERRW : ref_rd(a);
        end
        dq.push_back(r);
        m_lock = !a[2];
        m_fair = ip ? ((m_fair == 2'd3) ? 2'd3 : m_fair + 2'd1) : 2'd0;
        di++;
      end else if (ip && !m_lock) begin
        ram_q.push_back('{addr: ia, we: 1'b0, data: 32'd0, lat: ilat});
        if (ilat < 0) m_err = 1'b1;
        r.is_rd = 1'b1;
        r.err   = m_err;
        r.data  = (ilat < 0) ? ERRW : ref_rd(ia);
        iq.push_back(r);
        m_fair = 2'd0;
        ip = 1'b0;
      end else begin
        break;
      end
    end
  endtask

  task automatic wait_pulse(input bit is_d);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (is_d ? (bus.dwait === 1'b0) : (bus.iwait === 1'b0)) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no pulse in 100 cycles required=pulse", is_d ? "dwait" : "iwait");
    end
  endtask

  task automatic d_drive(input dreq_t dl[$]);
    foreach (dl[k]) begin
      bus.dREN   = !dl[k].we;
      bus.dWEN   = dl[k].we;
      bus.daddr  = dl[k].addr;
      bus.dstore = dl[k].data;
      wait_pulse(1'b1);
      @(posedge clk); #1;
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
      if (dl[k].gap > 0) begin
        repeat (dl[k].gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic i_drive(input logic [31:0] ia);
    bus.iREN  = 1'b1;
    bus.iaddr = ia;
    wait_pulse(1'b0);
    @(posedge clk); #1;
    bus.iREN = 1'b0;
  endtask

  task automatic run_round(input dreq_t dl[$], input bit i_en, input logic [31:0] ia, input int ilat);
    predict(dl, i_en, ia, ilat);
    @(posedge clk); #1;
    round_c0 = cyc;
    fork
      begin if (dl.size() > 0) d_drive(dl); end
      begin if (i_en) i_drive(ia); end
    join
  endtask

  function automatic int rnd_lat(input bit allow_to);
    if (allow_to && $urandom_range(0, 9) == 0) return -1;
    return int'($urandom_range(0, 7));
  endfunction

  // Response monitor
  logic prev_dw = 1'b1, prev_iw = 1'b1;
  rsp_t mr_d, mr_i;
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (bus.dwait === 1'b0) begin
        last_d_cyc = cyc;
        check("dwait_width", 32'(prev_dw), 32'd1);
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL d_unexpected actual=dwait pulse required=no pulse");
        end else begin
          mr_d = dq.pop_front();
          if (mr_d.is_rd) check("dload", bus.dload, mr_d.data);
          check("arb_err_d", 32'(arb_err), 32'(mr_d.err));
        end
      end
      if (bus.iwait === 1'b0) begin
        last_i_cyc = cyc;
        check("iwait_width", 32'(prev_iw), 32'd1);
        if (iq.size() == 0) begin
          total++; bad++;
          $display("FAIL i_unexpected actual=iwait pulse required=no pulse");
        end else begin
          mr_i = iq.pop_front();
          check("iload", bus.iload, mr_i.data);
          check("arb_err_i", 32'(arb_err), 32'(mr_i.err));
        end
      end
    end
    prev_dw = bus.dwait;
    prev_iw = bus.iwait;
  end

  // RAM responder and access-order monitor
  initial begin : ram_model
    logic prev_en, en;
    ram_exp_t e;
    logic [31:0] a, d;
    bus.ram_ready = 1'b0;
    bus.ramload   = 32'd0;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      en = bus.ramREN | bus.ramWEN;
      if (nrst !== 1'b1) begin
        prev_en = 1'b0;
      end else if (en && !prev_en) begin
        prev_en = 1'b1;
        if (ram_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ram_unexpected actual=access at %h required=none", bus.ramaddr);
        end else begin
          e = ram_q.pop_front();
          check("ramaddr", bus.ramaddr, e.addr);
          check("ramWEN", 32'(bus.ramWEN), 32'(e.we));
          check("ramREN", 32'(bus.ramREN), 32'(!e.we));
          if (e.we) check("ramstore", bus.ramstore, e.data);
          a = bus.ramaddr;
          d = bus.ramstore;
          if (e.lat >= 0) begin
            if (e.lat > 0) begin
              repeat (e.lat) @(posedge clk);
              #1;
            end
            bus.ramload   = e.we ? $urandom : ram_rd(a);
            bus.ram_ready = 1'b1;
            @(posedge clk); #1;
            bus.ram_ready = 1'b0;
            if (e.we) ram_mem[a] = d;
            // stray ready during DONE must be ignored
            if ($urandom_range(0, 3) == 0) begin
              bus.ram_ready = 1'b1;
              @(posedge clk); #1;
              bus.ram_ready = 1'b0;
            end
            prev_en = 1'b0;
          end
        end
      end else begin
        prev_en = en;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    dreq_t dl[$];
    bit i_en;
    logic [31:0] base, ia;
    int kind;

    bus.iREN = 1'b0; bus.iaddr = 32'd0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'd0; bus.dstore = 32'd0;
    m_lock = 1'b0; m_err = 1'b0; m_fair = 2'd0;
    nrst = 1'b0;

    #12;
    check("rst_iwait", 32'(bus.iwait), 32'd1);
    check("rst_dwait", 32'(bus.dwait), 32'd1);
    check("rst_iload", bus.iload, 32'd0);
    check("rst_dload", bus.dload, 32'd0);
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_ramstore", bus.ramstore, 32'd0);
    check("rst_arb_err", 32'(arb_err), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(posedge clk);

    // single icache read, ready 3 cycles after ramREN
    ram_mem[32'h40] = 32'h1234ABCD;
    ref_mem[32'h40] = 32'h1234ABCD;
    dl.delete();
    run_round(dl, 1'b1, 32'h40, 3);
    check("lat_i", 32'(last_i_cyc - round_c0), 32'd5);

    // simultaneous requests: dcache block 0x80/0x84 first, icache after
    dl.delete();
    dl.push_back(mk(1'b0, 32'h80, 32'd0, 1, 0));
    dl.push_back(mk(1'b0, 32'h84, 32'd0, 0, 0));
    run_round(dl, 1'b1, 32'h00, 2);

    // block writes with icache held high throughout
    dl.delete();
    dl.push_back(mk(1'b1, 32'h100, 32'hCAFE0001, 2, 0));
    dl.push_back(mk(1'b1, 32'h104, 32'hCAFE0002, 1, 0));
    run_round(dl, 1'b1, 32'h100, 0);

    // latest ready that still beats the timeout
    dl.delete();
    dl.push_back(mk(1'b0, 32'h104, 32'd0, TO - 1, 0));
    run_round(dl, 1'b0, 32'h0, 0);
    check("lat_d_edge", 32'(last_d_cyc - round_c0), 32'(TO + 1));

    // lock holds icache off while the dcache pauses between words
    dl.delete();
    dl.push_back(mk(1'b0, 32'h140, 32'd0, 1, 6));
    dl.push_back(mk(1'b1, 32'h144, 32'h5555AAAA, 1, 0));
    run_round(dl, 1'b1, 32'h144, 1);

    // four back-to-back word-1 reads with icache requesting
    dl.delete();
    for (int k = 0; k < 4; k++) dl.push_back(mk(1'b0, 32'h10C + 32'(k * 8), 32'd0, 0, 0));
    run_round(dl, 1'b1, 32'h60, 0);

    // hung RAM on a dcache read
    dl.delete();
    dl.push_back(mk(1'b0, 32'h304, 32'd0, -1, 0));
    run_round(dl, 1'b0, 32'h0, 0);
    check("lat_timeout", 32'(last_d_cyc - round_c0), 32'(TO + 1));
    repeat (3) @(negedge clk);
    check("arb_err_sticky", 32'(arb_err), 32'd1);

    for (int r = 0; r < 60; r++) begin
      dl.delete();
      kind = int'($urandom_range(0, 3));
      base = 32'($urandom_range(0, 15)) << 3;
      case (kind)
        1: dl.push_back(mk(1'($urandom_range(0, 1)), base | 32'h4, $urandom, rnd_lat(1'b1), 0));
        2, 3: begin
          dl.push_back(mk(1'($urandom_range(0, 1)), base, $urandom, rnd_lat(1'b1),
                          int'($urandom_range(0, 3))));
          dl.push_back(mk(1'($urandom_range(0, 1)), base | 32'h4, $urandom, rnd_lat(1'b1), 0));
        end
        default: ;
      endcase
      i_en = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ia = (32'($urandom_range(0, 15)) << 3) | (32'($urandom_range(0, 1)) << 2);
      run_round(dl, i_en, ia, rnd_lat(1'b1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // reset in the middle of a dcache access
    ram_q.push_back('{addr: 32'h200, we: 1'b0, data: 32'd0, lat: -1});
    @(posedge clk); #1;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h200;
    @(posedge clk); #1;
    bus.dREN = 1'b0;
    repeat (3) @(negedge clk);
    check("acc_before_rst", 32'(bus.ramREN), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("rst_mid_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_mid_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_mid_dwait", 32'(bus.dwait), 32'd1);
    check("rst_mid_arb_err", 32'(arb_err), 32'd0);
    check("rst_mid_ramaddr", bus.ramaddr, 32'd0);
    m_err = 1'b0; m_lock = 1'b0; m_fair = 2'd0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_dwait", 32'(bus.dwait), 32'd1);
    check("post_rst_ram_q", 32'(ram_q.size()), 32'd0);

    dl.delete();
    dl.push_back(mk(1'b0, 32'h100, 32'd0, 2, 0));
    dl.push_back(mk(1'b0, 32'h104, 32'd0, 1, 0));
    run_round(dl, 1'b1, 32'h40, 1);

    repeat (5) @(posedge clk);
    check("end_dq", 32'(dq.size()), 32'd0);
    check("end_iq", 32'(iq.size()), 32'd0);
    check("end_ram_q", 32'(ram_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
